md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Sequencing controller for the multiply/divide unit and the HI/LO register pair in the pipelined MIPS core.
- Accepts a start command from the E stage.
- Models the multi-cycle latency with a busy counter, then commits results to HI/LO.
- Drives the stall request that holds any D-stage mult/div/mfhi/mflo/mthi/mtlo instruction until the unit is free.

Parameters:
- MULT_CYCLES, 5, busy duration in cycles for mult/multu (and madd); legal range 1..15.
- DIV_CYCLES, 10, busy duration in cycles for div/divu; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-low reset; reset==0 at a rising edge clears all state.
- start  input  1  E-stage command valid, one cycle per instruction.
- md_op  input  4  0001 mult, 0010 multu, 0011 div, 0100 divu, 0101 mthi, 0110 mtlo, 0111 madd (feature only); all other codes are no-ops.
- a  input  32  rs operand.
- b  input  32  rt operand.
- md_useD  input  1  D-stage instruction is an md-class instruction (includes mfhi/mflo).
- busy  output  1  unit is executing a mult/div.
- stallD  output  1  stall request to the hazard unit.
- hi  output  32  HI register.
- lo  output  32  LO register.

Behaviour:
- Reset values: busy=0, stallD=0, hi=0, lo=0, counter=0, state=IDLE. Any operation in flight is aborted with no commit.
- States are IDLE and BUSY. The counter is 4 bits.
- IDLE, start=1, op in {mult, multu, div, divu, madd}:
  - Compute the result into pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - Go to BUSY.
- Timing: start is sampled at edge T. busy=1 for exactly N cycles, T+1..T+N. At the edge ending cycle T+N, when counter==1, pending is written to HI/LO and the state returns to IDLE. New values are visible and busy=0 at T+N+1.
- BUSY, per cycle: counter decrements by 1.
- mult: {HI,LO} = signed 64-bit product.
- multu: {HI,LO} = unsigned 64-bit product.
- div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
- divu: unsigned quotient and remainder.
- Divide by zero: HI/LO are left unchanged at commit. The operation still takes DIV_CYCLES.
- mthi/mtlo in IDLE: HI/LO is written from `a` at the sampling edge, single cycle, with no busy.
- start while BUSY: ignored, with no state change. The hazard unit must not allow this; the bench flags it as an error.
- Unknown md_op with start=1: no-op.
- stallD = md_useD & (busy | (start & op is mult/multu/div/divu/madd)). This is combinational, so a dependent instruction directly behind a mult is stalled in its first cycle.
- hi/lo are read directly by the mfhi/mflo forwarding mux. They never change while busy=1.

Optional Feature:
- Macro MD_MADD_EN.
- Defined:
  - md_op 0111 (madd) is legal, with busy for MULT_CYCLES.
  - Commit value is {HI,LO} + signed(a)*signed(b), in 64-bit wrap-around arithmetic.
  - The accumulate base is the HI/LO value at the start edge.
- Not defined: 0111 is a no-op and raises neither busy nor stallD.

Test Plan:
- Reset, then start mult a=32'hFFFF_FFFE (-2), b=3 -> busy high cycles 1..5; at cycle 6 hi=FFFF_FFFF, lo=FFFF_FFFA.
- multu a=FFFF_FFFF, b=2 -> after 5 busy cycles hi=0000_0001, lo=FFFF_FFFE.
- div a=-7 (FFFF_FFF9), b=2 -> busy 10 cycles; lo=FFFF_FFFD, hi=FFFF_FFFF. divu a=7, b=0 -> hi/lo unchanged after 10 cycles.
- mult issued with md_useD=1 in the same cycle -> stallD=1 from the start cycle through the last busy cycle, 0 afterwards. A second start while busy is ignored and the result matches the first op.
- mthi a=1234_5678, then mtlo a=9ABC_DEF0 -> hi/lo take the values one cycle after each start. Reset driven low at busy cycle 3 of a div -> next cycle busy=0, hi=lo=0, no later commit.
- With MD_MADD_EN: hi=0, lo=5, then madd a=2, b=3 -> lo=11 after 5 cycles. Without the macro: busy stays 0 and lo stays 5.

Source files
------------

// File: rtl/md_ctrl_if.sv
// md_ctrl_if: E-stage command and HI/LO result bundle for the mult/div controller.
//   master (pipeline side): drives start, md_op, a, b, md_useD; reads busy, stallD, hi, lo
//   slave  (md_ctrl side) : the reverse
interface md_ctrl_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] a;
    logic [31:0] b;
    logic        md_useD;
    logic        busy;
    logic        stallD;
    logic [31:0] hi;
    logic [31:0] lo;
    modport master (output start, md_op, a, b, md_useD, input busy, stallD, hi, lo);
    modport slave  (input start, md_op, a, b, md_useD, output busy, stallD, hi, lo);
endinterface

// File: rtl/md_ctrl.sv
// md_ctrl: multi-cycle mult/div sequencer owning the HI/LO pair, with D-stage stall request.
//   clk   : rising-edge clock
//   reset : synchronous active-low reset
//   io    : md_ctrl_if.slave (start/md_op/a/b/md_useD in; busy/stallD/hi/lo out)
//   Macro MD_MADD_EN enables md_op 0111 (madd: {HI,LO} += signed a*b).
module md_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic     clk,
    input logic     reset,
    md_ctrl_if.slave io
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;

    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, nextState;

    logic [3:0]         counter;
    logic [31:0]        hiReg, loReg, pendHi, pendLo;
    logic               pendOk;
    logic               isMult, isMultu, isDiv, isDivu, isMadd, isLong;
    logic [63:0]        sProd, uProd, resHiLo;
    logic signed [31:0] sQuot, sRem;
    logic [31:0]        uQuot, uRem;
    logic               resOk;

    assign isMult  = io.md_op == OP_MULT;
    assign isMultu = io.md_op == OP_MULTU;
    assign isDiv   = io.md_op == OP_DIV;
    assign isDivu  = io.md_op == OP_DIVU;
`ifdef MD_MADD_EN
    assign isMadd  = io.md_op == OP_MADD;
`else
    assign isMadd  = 1'b0;
`endif
    assign isLong  = isMult | isMultu | isDiv | isDivu | isMadd;

    // Explicit 64-bit extension keeps the low 64 bits of the product exact for both signednesses.
    assign sProd = {{32{io.a[31]}}, io.a} * {{32{io.b[31]}}, io.b};
    assign uProd = {32'b0, io.a} * {32'b0, io.b};
    assign sQuot = $signed(io.a) / $signed(io.b);
    assign sRem  = $signed(io.a) % $signed(io.b);
    assign uQuot = io.a / io.b;
    assign uRem  = io.a % io.b;

    always_comb begin
        resHiLo = isMultu ? uProd :
                  isDiv   ? {sRem, sQuot} :
                  isDivu  ? {uRem, uQuot} :
                  isMadd  ? {hiReg, loReg} + sProd : sProd;
        // Divide by zero still occupies the unit but leaves HI/LO untouched at commit.
        resOk = !((isDiv | isDivu) && io.b == 32'd0);
    end

    always_comb begin
        nextState = state;
        if (state == IDLE && io.start && isLong)
            nextState = BUSY;
        else if (state == BUSY && counter == 4'd1)
            nextState = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            counter <= 4'd0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            pendHi  <= 32'd0;
            pendLo  <= 32'd0;
            pendOk  <= 1'b0;
        end else begin
            state <= nextState;
            if (state == IDLE) begin
                if (io.start && isLong) begin
                    {pendHi, pendLo} <= resHiLo;
                    pendOk  <= resOk;
                    counter <= (isDiv | isDivu) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
                end else if (io.start && io.md_op == OP_MTHI) begin
                    hiReg <= io.a;
                end else if (io.start && io.md_op == OP_MTLO) begin
                    loReg <= io.a;
                end
            end else begin
                counter <= counter - 4'd1;
                if (counter == 4'd1 && pendOk) begin
                    hiReg <= pendHi;
                    loReg <= pendLo;
                end
            end
        end
    end

    assign io.busy   = state == BUSY;
    // Combinational so the instruction right behind a mult/div stalls in its first cycle.
    assign io.stallD = io.md_useD & (io.busy | (io.start & isLong));
    assign io.hi     = hiReg;
    assign io.lo     = loReg;
endmodule
